// File: rtl/shift_pkg.sv
// Purpose : shared types for the shift engine: operation codes, FSM states and
//           a helper that classifies the stepping operations.
// Contents: shift_mode_t (3-bit opcode), state_t (IDLE/SHIFT/DONE), is_shift().
package shift_pkg;

   typedef enum logic [2:0] {
      LOAD = 3'd0,
      SHL  = 3'd1,
      SHR  = 3'd2,
      ROL  = 3'd3,
      ROR  = 3'd4,
      ASR  = 3'd5,
      CLR  = 3'd6,
      NOP  = 3'd7
   } shift_mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // True for opcodes that run through the SHIFT state one bit per cycle.
   function automatic logic is_shift(shift_mode_t m);
      return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR) || (m == ASR);
   endfunction

endpackage

// File: rtl/shift_engine_if.sv
// Purpose : request/result bundle between a requester and shift_engine.
// Signals : start/mode/amount/sin/load_data (requester -> engine),
//           out/cout/busy/done (engine -> requester).
// Modports: master = requester side, slave = engine side.
interface shift_engine_if
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) ();

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic              start;
   shift_mode_t       mode;
   logic [CNT_W-1:0]  amount;
   logic              sin;
   logic [WIDTH-1:0]  load_data;
   logic [WIDTH-1:0]  out;
   logic              cout;
   logic              busy;
   logic              done;

   modport master (
      output start, mode, amount, sin, load_data,
      input  out, cout, busy, done
   );

   modport slave (
      input  start, mode, amount, sin, load_data,
      output out, cout, busy, done
   );

endinterface

// File: rtl/shift_engine_step.sv
// Purpose : single-step shift/rotate datapath, purely combinational.
// Ports   : i_mode  - latched opcode
//           i_out   - current data register
//           i_sin   - serial fill bit for SHL/SHR
//           o_next_out_c / o_next_cout_c - data and carry after one step
module shift_step
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  shift_mode_t      i_mode,
   input  logic [WIDTH-1:0] i_out,
   input  logic             i_sin,
   output logic [WIDTH-1:0] o_next_out_c,
   output logic             o_next_cout_c
);

   // Non-stepping opcodes never reach this path; they fall through as a hold.
   always_comb begin
      o_next_out_c  = i_out;
      o_next_cout_c = 1'b0;
      case (i_mode)
         SHL: begin
            o_next_out_c  = {i_out[WIDTH-2:0], i_sin};
            o_next_cout_c = i_out[WIDTH-1];
         end
         SHR: begin
            o_next_out_c  = {i_sin, i_out[WIDTH-1:1]};
            o_next_cout_c = i_out[0];
         end
         ROL: begin
            o_next_out_c  = {i_out[WIDTH-2:0], i_out[WIDTH-1]};
            o_next_cout_c = i_out[WIDTH-1];
         end
         ROR: begin
            o_next_out_c  = {i_out[0], i_out[WIDTH-1:1]};
            o_next_cout_c = i_out[0];
         end
         ASR: begin
            o_next_out_c  = {i_out[WIDTH-1], i_out[WIDTH-1:1]};
            o_next_cout_c = i_out[0];
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/shift_engine.sv
// Purpose : multi-cycle shift/rotate engine. One operation per start accepted
//           in IDLE; shifting opcodes take one cycle per bit, then a one-cycle
//           DONE state pulses done.
// Ports   : clk  - clock, rising edge
//           rstn - asynchronous active-low reset
//           bus  - shift_engine_if.slave (request in, registered results out)
module shift_engine
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic           clk,
   input  logic           rstn,
   shift_engine_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   state_t            r_state;
   shift_mode_t       r_mode;
   logic [CNT_W-1:0]  r_count;
   logic [WIDTH-1:0]  r_out;
   logic              r_cout;
   logic              r_busy;
   logic              r_done;

   logic [WIDTH-1:0]  w_next_out;
   logic              w_next_cout;
   logic [CNT_W-1:0]  w_count_init;

   // Requests longer than the register are clamped silently.
   assign w_count_init = (bus.amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.amount;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .i_mode        (r_mode),
      .i_out         (r_out),
      .i_sin         (bus.sin),
      .o_next_out_c  (w_next_out),
      .o_next_cout_c (w_next_cout)
   );

   // Control FSM and data register; busy/done are registered alongside state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_mode  <= NOP;
         r_count <= '0;
         r_out   <= '0;
         r_cout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_mode <= bus.mode;
                  r_busy <= 1'b1;
                  if (is_shift(bus.mode) && (bus.amount != '0)) begin
                     r_count <= w_count_init;
                     r_state <= SHIFT;
                  end else begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                     if (bus.mode == LOAD) begin
                        r_out <= bus.load_data;
                     end else if (bus.mode == CLR) begin
                        r_out  <= '0;
                        r_cout <= 1'b0;
                     end
                  end
               end
            end
            SHIFT: begin
               r_out   <= w_next_out;
               r_cout  <= w_next_cout;
               r_count <= r_count - CNT_W'(1);
               // Final step and the move to DONE share one edge.
               if (r_count == CNT_W'(1)) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out  = r_out;
   assign bus.cout = r_cout;
   assign bus.busy = r_busy;
   assign bus.done = r_done;

endmodule

// File: tb/tb_shift_engine.sv
// Purpose : self-checking bench for shift_engine (WIDTH=8). Expected results
//           are queued on issue and checked when done pulses; hand sequences
//           cover per-step values, ignored mid-run start and reset abort.
module tb_shift_engine;
   import shift_pkg::*;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   cyc  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   shift_engine_if #(.WIDTH(WIDTH)) bus ();

   shift_engine #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   typedef struct {
      logic [7:0] e_out;
      logic       e_cout;
      int         done_at;
   } exp_t;

   typedef struct {
      shift_mode_t      mode;
      logic [CNT_W-1:0] amount;
      logic [7:0]       load;
      logic             sin;
      logic [7:0]       e_out;
      logic             e_cout;
      int               steps;
   } vec_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, exp, $time);
   endtask

   // Scoreboard side: every done pulse must match the oldest queued request.
   logic prev_done = 1'b0;
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (bus.done) begin
         check("done_one_cycle", 32'(prev_done), 32'(0));
         check("done_expected", 32'(sb.size() != 0), 32'(1));
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("result_out", 32'(bus.out), 32'(e.e_out));
            check("result_cout", 32'(bus.cout), 32'(e.e_cout));
            check("done_latency", 32'(cyc), 32'(e.done_at));
         end
      end
      prev_done = bus.done;
   end

   // Waits for IDLE, pulses start for one accept edge, then scrambles inputs.
   task automatic issue(input shift_mode_t m, input logic [CNT_W-1:0] a, input logic [7:0] ld,
                        input logic s, input logic [7:0] eo, input logic ec, input int steps,
                        input bit push);
      exp_t e;
      int w = 0;
      while (bus.busy && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      if (bus.busy) check("issue_wait_idle", 32'(bus.busy), 32'(0));
      bus.start     = 1'b1;
      bus.mode      = m;
      bus.amount    = a;
      bus.load_data = ld;
      bus.sin       = s;
      if (push) begin
         e.e_out   = eo;
         e.e_cout  = ec;
         e.done_at = cyc + 1 + steps;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.mode      = shift_mode_t'(3'($urandom_range(0, 7)));
      bus.amount    = CNT_W'($urandom_range(0, 15));
      bus.load_data = 8'($urandom);
   endtask

   // Counts cycles with busy high, starting at the accept edge.
   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy && n < 40) begin
         n++;
         @(posedge clk); #1;
      end
      if (bus.busy) check("wait_idle_timeout", 32'(bus.busy), 32'(0));
   endtask

   vec_t       tbl[14];
   logic [7:0] shl_o[3];
   logic       shl_c[3];
   int         n;

   initial begin
      bus.start     = 1'b0;
      bus.mode      = NOP;
      bus.amount    = '0;
      bus.sin       = 1'b0;
      bus.load_data = '0;

      tbl[0]  = '{LOAD, 4'd0,  8'h96, 1'b0, 8'h96, 1'b1, 0};
      tbl[1]  = '{ASR,  4'd2,  8'h00, 1'b0, 8'hE5, 1'b1, 2};
      tbl[2]  = '{LOAD, 4'd0,  8'h3C, 1'b0, 8'h3C, 1'b1, 0};
      tbl[3]  = '{SHL,  4'd0,  8'h00, 1'b1, 8'h3C, 1'b1, 0};
      tbl[4]  = '{NOP,  4'd5,  8'hFF, 1'b1, 8'h3C, 1'b1, 0};
      tbl[5]  = '{SHR,  4'd4,  8'h00, 1'b0, 8'h03, 1'b1, 4};
      tbl[6]  = '{ROL,  4'd1,  8'h00, 1'b0, 8'h06, 1'b0, 1};
      tbl[7]  = '{CLR,  4'd0,  8'h55, 1'b0, 8'h00, 1'b0, 0};
      tbl[8]  = '{LOAD, 4'd0,  8'h81, 1'b0, 8'h81, 1'b0, 0};
      tbl[9]  = '{ROL,  4'd15, 8'h00, 1'b0, 8'h81, 1'b1, 8};
      tbl[10] = '{SHR,  4'd2,  8'h00, 1'b1, 8'hE0, 1'b0, 2};
      tbl[11] = '{ASR,  4'd8,  8'h00, 1'b0, 8'hFF, 1'b1, 8};
      tbl[12] = '{SHL,  4'd2,  8'h00, 1'b0, 8'hFC, 1'b1, 2};
      tbl[13] = '{LOAD, 4'd0,  8'h3C, 1'b0, 8'h3C, 1'b1, 0};
      shl_o   = '{8'h4B, 8'h97, 8'h2F};
      shl_c   = '{1'b1, 1'b0, 1'b1};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out", 32'(bus.out), 32'(0));
      check("rst_cout", 32'(bus.cout), 32'(0));
      check("rst_busy", 32'(bus.busy), 32'(0));
      check("rst_done", 32'(bus.done), 32'(0));
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;

      // LOAD 0xA5: busy for the DONE cycle only
      issue(LOAD, 4'd0, 8'hA5, 1'b0, 8'hA5, 1'b0, 0, 1'b1);
      check("load_out_after_accept", 32'(bus.out), 32'h0000_00A5);
      wait_idle(n);
      check("load_busy_cycles", 32'(n), 32'(1));

      // SHL by 3 with sin=1, value checked every step
      issue(SHL, 4'd3, 8'h00, 1'b1, 8'h2F, 1'b1, 3, 1'b1);
      check("shl_hold_at_accept", 32'(bus.out), 32'h0000_00A5);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check($sformatf("shl_step%0d_out", k), 32'(bus.out), 32'(shl_o[k]));
         check($sformatf("shl_step%0d_cout", k), 32'(bus.cout), 32'(shl_c[k]));
      end
      wait_idle(n);

      // Table-driven operations
      for (int i = 0; i < 14; i++) begin
         issue(tbl[i].mode, tbl[i].amount, tbl[i].load, tbl[i].sin,
               tbl[i].e_out, tbl[i].e_cout, tbl[i].steps, 1'b1);
         wait_idle(n);
         check($sformatf("vec%0d_busy_cycles", i), 32'(n), 32'(tbl[i].steps + 1));
      end

      // ROR 9 clamps to 8 steps; a start mid-SHIFT must be dropped
      issue(ROR, 4'd9, 8'h00, 1'b0, 8'h3C, 1'b0, 8, 1'b1);
      n = 0;
      while (bus.busy && n < 40) begin
         n++;
         if (n == 4) begin
            bus.start     = 1'b1;
            bus.mode      = LOAD;
            bus.load_data = 8'hFF;
         end
         if (n == 5) bus.start = 1'b0;
         @(posedge clk); #1;
      end
      check("ror_busy_cycles", 32'(n), 32'(9));
      check("ror_final_out", 32'(bus.out), 32'h0000_003C);
      repeat (2) @(posedge clk);
      #1;
      check("ror_no_queued_start", 32'(bus.busy), 32'(0));

      // Reset mid-SHIFT aborts immediately, then LOAD on the first edge
      issue(SHL, 4'd8, 8'h00, 1'b0, 8'h00, 1'b0, 8, 1'b0);
      @(posedge clk); #3;
      rstn = 1'b0;
      #1;
      check("abort_out", 32'(bus.out), 32'(0));
      check("abort_cout", 32'(bus.cout), 32'(0));
      check("abort_busy", 32'(bus.busy), 32'(0));
      check("abort_done", 32'(bus.done), 32'(0));
      repeat (2) @(posedge clk);
      @(negedge clk) rstn = 1'b1;
      #1;
      issue(LOAD, 4'd0, 8'h11, 1'b0, 8'h11, 1'b0, 0, 1'b1);
      wait_idle(n);
      check("post_reset_load", 32'(bus.out), 32'h0000_0011);

      repeat (3) @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(sb.size()), 32'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
